// File: rtl/turn_signal_ctrl_pkg.sv
// Shared car definitions for the turn-signal controller: mode encodings,
// FSM state encoding and small lamp-decode helpers.
package turn_signal_ctrl_pkg;

    // Driver-selected operating mode. Only MODE_OFF changes behaviour here;
    // the three active modes blink identically.
    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_MANUAL = 2'b01;
    localparam logic [1:0] MODE_SEMI   = 2'b10;
    localparam logic [1:0] MODE_AUTO   = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LEFT   = 2'b01,
        RIGHT  = 2'b10,
        HAZARD = 2'b11
    } state_t;

    // True when the left lamp belongs to the blinking set in state s.
    function automatic logic drives_left(input state_t s);
        return (s == LEFT) || (s == HAZARD);
    endfunction

    // True when the right lamp belongs to the blinking set in state s.
    function automatic logic drives_right(input state_t s);
        return (s == RIGHT) || (s == HAZARD);
    endfunction

endpackage

// File: rtl/turn_signal_ctrl_blink_timer.sv
// Half-period timer: counts 0..HALF_PERIOD-1, toggles phase on every wrap.
// clear forces counter=0 and phase=1 so a newly entered state starts lit.
// fall is a registered pulse, high in the first cycle of each off half.
// last flags the terminal count, i.e. phase toggles at the coming edge
// unless clear is asserted.
module blink_timer #(
    parameter int HALF_PERIOD = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic phase,
    output logic fall,
    output logic last
);

    localparam int CW = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] cnt;

    assign last = (cnt == LAST_CNT);

    // Counter, phase and fall pulse; clear has priority over the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
            fall  <= 1'b0;
        end else if (clear) begin
            cnt   <= '0;
            phase <= 1'b1;
            fall  <= 1'b0;
        end else if (last) begin
            cnt   <= '0;
            phase <= ~phase;
            fall  <= phase;
        end else begin
            cnt   <= cnt + 1'b1;
            fall  <= 1'b0;
        end
    end

endmodule

// File: rtl/turn_signal_ctrl.sv
// Turn-signal / hazard controller. One FSM (IDLE, LEFT, RIGHT, HAZARD)
// drives a shared blink timer; every state entry restarts the blink with
// the lamp lit. LEFT/RIGHT honour a comfort-flash minimum and leave only
// at the end of an off half, so the lamp is dark on exit.
// Lamp outputs and busy are registered from the next state and next phase
// so they line up with the state register cycle for cycle.
module turn_signal_ctrl
    import turn_signal_ctrl_pkg::*;
#(
    parameter int HALF_PERIOD     = 50_000_000,
    parameter int COMFORT_FLASHES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       turn_left,
    input  logic       turn_right,
    input  logic       hazard,
    output logic       left_light,
    output logic       right_light,
    output logic       busy
);

    localparam int FW = $clog2(COMFORT_FLASHES + 1);
    localparam logic [FW-1:0] FLASH_MAX = FW'(COMFORT_FLASHES);

    state_t        state;
    state_t        state_nxt;
    logic [FW-1:0] flash_cnt;
    logic          phase;
    logic          fall;
    logic          last;
    logic          entry;
    logic          clear;
    logic          phase_nxt;
    logic          comfort_done;

    blink_timer #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .phase (phase),
        .fall  (fall),
        .last  (last)
    );

    // Minimum flashes done and the current off half ends at this edge.
    assign comfort_done = (flash_cnt == FLASH_MAX) && !phase && last;

    // Next-state decode: power-off first, then hazard / both-turns, then
    // single requests with the comfort rule for LEFT/RIGHT exit.
    always_comb begin
        state_nxt = state;
        if (mode == MODE_OFF) begin
            state_nxt = IDLE;
        end else if (hazard || (turn_left && turn_right)) begin
            state_nxt = HAZARD;
        end else begin
            case (state)
                IDLE: begin
                    if (turn_left)       state_nxt = LEFT;
                    else if (turn_right) state_nxt = RIGHT;
                end
                LEFT: begin
                    if (turn_right)                    state_nxt = RIGHT;
                    else if (!turn_left && comfort_done) state_nxt = IDLE;
                end
                RIGHT: begin
                    if (turn_left)                      state_nxt = LEFT;
                    else if (!turn_right && comfort_done) state_nxt = IDLE;
                end
                HAZARD: begin
                    if (turn_left)       state_nxt = LEFT;
                    else if (turn_right) state_nxt = RIGHT;
                    else                 state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Timer restart on entry into a blinking state; held cleared in IDLE.
    always_comb begin
        entry     = (state_nxt != state) && (state_nxt != IDLE);
        clear     = entry || (state_nxt == IDLE);
        phase_nxt = clear ? 1'b1 : (last ? ~phase : phase);
    end

    // FSM state, saturating flash counter and registered lamp/busy outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            flash_cnt   <= '0;
            left_light  <= 1'b0;
            right_light <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (clear) begin
                flash_cnt <= '0;
            end else if (fall && (flash_cnt != FLASH_MAX)) begin
                flash_cnt <= flash_cnt + 1'b1;
            end
            left_light  <= phase_nxt && drives_left(state_nxt);
            right_light <= phase_nxt && drives_right(state_nxt);
            busy        <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Directed bench for turn_signal_ctrl with HALF_PERIOD=4, COMFORT_FLASHES=3.
// Inputs change 1 ns after a rising edge and outputs are sampled at the
// same point, so cycle n below is the n-th cycle after the sampling edge.
module tb_turn_signal_ctrl;
    import turn_signal_ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic       turn_left;
    logic       turn_right;
    logic       hazard;
    logic       left_light;
    logic       right_light;
    logic       busy;

    int checks = 0;
    int errors = 0;

    turn_signal_ctrl #(
        .HALF_PERIOD     (4),
        .COMFORT_FLASHES (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .turn_left   (turn_left),
        .turn_right  (turn_right),
        .hazard      (hazard),
        .left_light  (left_light),
        .right_light (right_light),
        .busy        (busy)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compares {left_light, right_light, busy} against the expected triple.
    task automatic check(input string tag, input logic [2:0] exp);
        logic [2:0] obs;
        obs = {left_light, right_light, busy};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed {left,right,busy}=%b expected %b", tag, obs, exp);
        end
    endtask

    // Expected lamp level in cycle n (1-based) of a freshly entered state.
    function automatic logic lit(input int n);
        return ((n - 1) / 4) % 2 == 0;
    endfunction

    initial begin
        rst_n      = 1'b0;
        mode       = MODE_MANUAL;
        turn_left  = 1'b0;
        turn_right = 1'b0;
        hazard     = 1'b0;
        #1;
        check("reset_state", 3'b000);
        tick();
        tick();
        #4 rst_n = 1'b1;
        tick();
        check("idle_after_reset", 3'b000);

        // 1-cycle left pulse: three full flashes, busy for 24 cycles.
        turn_left = 1'b1;
        tick();
        turn_left = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            check($sformatf("pulse_left_c%0d", i), {lit(i), 1'b0, 1'b1});
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("pulse_left_idle%0d", i), 3'b000);
            tick();
        end

        // Left held for 40 sampled edges: released at the end of an off half.
        turn_left = 1'b1;
        tick();
        for (int i = 1; i <= 40; i++) begin
            check($sformatf("hold40_c%0d", i), {lit(i), 1'b0, 1'b1});
            if (i == 40) turn_left = 1'b0;
            tick();
        end
        check("hold40_exit", 3'b000);
        tick();

        // Left held for 42 edges: released mid on-half, finishes the flash.
        turn_left = 1'b1;
        tick();
        for (int i = 1; i <= 48; i++) begin
            check($sformatf("hold42_c%0d", i), {lit(i), 1'b0, 1'b1});
            if (i == 42) turn_left = 1'b0;
            tick();
        end
        check("hold42_exit", 3'b000);
        tick();

        // LEFT -> RIGHT switch in cycle 6, right blink restarts lit.
        turn_left = 1'b1;
        tick();
        for (int i = 1; i <= 6; i++) begin
            check($sformatf("switch_left_c%0d", i), {lit(i), 1'b0, 1'b1});
            if (i == 6) begin
                turn_left  = 1'b0;
                turn_right = 1'b1;
            end
            tick();
        end
        for (int j = 1; j <= 24; j++) begin
            check($sformatf("switch_right_c%0d", j), {1'b0, lit(j), 1'b1});
            if (j == 5) turn_right = 1'b0;
            tick();
        end
        check("switch_right_exit", 3'b000);
        tick();

        // Hazard during RIGHT, then hazard release with no request -> IDLE.
        turn_right = 1'b1;
        tick();
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("haz_right_c%0d", i), 3'b011);
            if (i == 3) hazard = 1'b1;
            tick();
        end
        for (int k = 1; k <= 10; k++) begin
            check($sformatf("haz_c%0d", k), {lit(k), lit(k), 1'b1});
            if (k == 1) turn_right = 1'b0;
            if (k == 10) hazard = 1'b0;
            tick();
        end
        check("haz_exit_idle", 3'b000);
        tick();

        // Power-off mid-flash in LEFT; requests ignored while off.
        turn_left = 1'b1;
        tick();
        for (int i = 1; i <= 6; i++) begin
            check($sformatf("off_left_c%0d", i), {lit(i), 1'b0, 1'b1});
            if (i == 6) mode = MODE_OFF;
            tick();
        end
        check("off_exit", 3'b000);
        hazard = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("off_ignored%0d", i), 3'b000);
        end
        hazard    = 1'b0;
        turn_left = 1'b0;
        mode      = MODE_SEMI;
        tick();
        check("off_back_on_idle", 3'b000);

        // Both turns -> HAZARD; dropping one during an off half restarts lit.
        turn_left  = 1'b1;
        turn_right = 1'b1;
        tick();
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("both_c%0d", k), {lit(k), lit(k), 1'b1});
            if (k == 5) turn_right = 1'b0;
            tick();
        end
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("haz_to_left_c%0d", i), 3'b101);
            tick();
        end
        mode = MODE_OFF;
        tick();
        check("haz_to_left_off", 3'b000);
        turn_left = 1'b0;
        mode      = MODE_AUTO;
        tick();

        // Reset asserted mid-HAZARD clears outputs before the next edge.
        hazard = 1'b1;
        tick();
        check("rst_haz_c1", 3'b111);
        tick();
        check("rst_haz_c2", 3'b111);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_clear", 3'b000);
        tick();
        check("rst_held", 3'b000);
        hazard = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        check("rst_release_idle", 3'b000);
        tick();
        check("rst_release_idle2", 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
